ift_seq: RTL and testbench

Sequencer for the bit-serial IFT processing-element array. Drives the shared control bus that every `ifp` element registers each cycle: `run`, `state`, `pathfunction`, `neighborhood`, `data_type`, `direction`, `carry_in`, `mem_send`, `mem_receive`. It runs one complete transform: serial load, alternating forward/backward propagation sweeps until convergence, then serial unload. It sits between the host/DMA front end and the PE array.

---
 rtl/ift_pkg.sv | 26 ++
 rtl/ift_phase_cnt.sv | 24 ++
 rtl/ift_seq.sv | 198 +++++++++++++++++++
 tb/tb_ift_seq.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ift_pkg.sv
// rtl/ift_pkg.sv - shared encodings for the IFT sequencer and processing-element array.
package ift_pkg;

   localparam logic [1:0] STOP_ST = 2'b00;
   localparam logic [1:0] COST_ST = 2'b01;
   localparam logic [1:0] ROOT_ST = 2'b10;
   localparam logic [1:0] SAVE_ST = 2'b11;

   localparam logic C8L16 = 1'b0;
   localparam logic C16L8 = 1'b1;

   localparam int CHAIN_LEN_DEF = 38;
   localparam int SAVE_LEN_DEF  = 28;

   typedef enum logic [2:0] {
      SEQ_IDLE,
      SEQ_LOAD,
      SEQ_INIT,
      SEQ_COST,
      SEQ_ROOT,
      SEQ_SAVE,
      SEQ_CHECK,
      SEQ_UNLOAD
   } seq_state_t;

endpackage

// File: rtl/ift_phase_cnt.sv
// rtl/ift_phase_cnt.sv - loadable 6-bit down-counter; o_tc flags the last cycle of a phase.
module ift_phase_cnt (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_load,
   input  logic [5:0] i_value,
   output logic       o_tc
);

   logic [5:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_value;
      end else if (r_cnt != 6'd0) begin
         r_cnt <= r_cnt - 6'd1;
      end
   end

   assign o_tc = (r_cnt == 6'd0);

endmodule

// File: rtl/ift_seq.sv
// rtl/ift_seq.sv - IFT array sequencer: load, propagation sweeps to convergence, unload.
// Optional sweep limit enabled by defining IFT_SEQ_TIMEOUT_EN.
module ift_seq
   import ift_pkg::*;
#(
   parameter int CHAIN_LEN  = CHAIN_LEN_DEF,
   parameter int SAVE_LEN   = SAVE_LEN_DEF,
   parameter int MAX_SWEEPS = 64
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       start,
   input  logic [1:0] cfg_pathfunction,
   input  logic       cfg_neighborhood,
   input  logic       cfg_data_type,
   input  logic       any_changed,
   output logic       run,
   output logic       carry_in,
   output logic       direction,
   output logic       mem_send,
   output logic       mem_receive,
   output logic [1:0] state,
   output logic [1:0] pathfunction,
   output logic       neighborhood,
   output logic       data_type,
   output logic       sweep_clr,
   output logic       busy,
   output logic       done,
   output logic       timeout,
   output logic [7:0] sweeps
);

`ifdef IFT_SEQ_TIMEOUT_EN
   localparam logic TMO_EN = 1'b1;
`else
   localparam logic TMO_EN = 1'b0;
`endif

   seq_state_t r_state;
   seq_state_t w_state_nxt;
   logic       w_tc;
   logic       w_cnt_load;
   logic [5:0] w_cnt_value;
   logic [2:0] r_nb;
   logic       w_nb_last;
   logic       w_accept;
   logic       w_check;
   logic       w_tmo_hit;
   logic       w_run;
   logic [1:0] w_phase;
   logic       w_carry;
   logic       w_recv;
   logic       w_send;
   logic       w_clr;
   logic       w_busy;
   logic       w_done;

   assign w_accept  = (r_state == SEQ_IDLE) && start;
   assign w_check   = (r_state == SEQ_CHECK);
   assign w_nb_last = (r_nb == (neighborhood ? 3'd7 : 3'd3));
   assign w_tmo_hit = TMO_EN && any_changed &&
                      (({1'b0, sweeps} + 9'd1) == 9'(MAX_SWEEPS));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= SEQ_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         SEQ_IDLE:   if (start) w_state_nxt = SEQ_LOAD;
         SEQ_LOAD:   if (w_tc) w_state_nxt = SEQ_INIT;
         SEQ_INIT:   w_state_nxt = SEQ_COST;
         SEQ_COST:   if (w_tc) w_state_nxt = SEQ_ROOT;
         SEQ_ROOT:   if (w_tc) w_state_nxt = SEQ_SAVE;
         SEQ_SAVE:   if (w_tc) w_state_nxt = w_nb_last ? SEQ_CHECK : SEQ_COST;
         SEQ_CHECK:  w_state_nxt = (any_changed && !w_tmo_hit) ? SEQ_INIT : SEQ_UNLOAD;
         SEQ_UNLOAD: if (w_tc) w_state_nxt = SEQ_IDLE;
         default:    w_state_nxt = SEQ_IDLE;
      endcase
   end

   // Outputs are decoded from the next state and registered, so they line up with r_state.
   always_comb begin
      w_run   = 1'b0;
      w_phase = STOP_ST;
      w_carry = 1'b0;
      w_recv  = 1'b0;
      w_send  = 1'b0;
      w_clr   = 1'b0;
      w_busy  = 1'b1;
      w_done  = 1'b0;
      case (w_state_nxt)
         SEQ_IDLE: begin
            w_busy = 1'b0;
            w_done = (r_state == SEQ_UNLOAD);
         end
         SEQ_LOAD: w_recv = 1'b1;
         SEQ_INIT: begin
            w_run = 1'b1;
            w_clr = 1'b1;
         end
         SEQ_COST: begin
            w_run   = 1'b1;
            w_phase = COST_ST;
            w_carry = (r_state != SEQ_COST);
         end
         SEQ_ROOT: begin
            w_run   = 1'b1;
            w_phase = ROOT_ST;
            w_carry = (r_state != SEQ_ROOT);
         end
         SEQ_SAVE: begin
            w_run   = 1'b1;
            w_phase = SAVE_ST;
         end
         SEQ_UNLOAD: w_send = 1'b1;
         default: ;
      endcase
   end

   // Every phase transition reloads the counter with (length - 1) of the phase being entered.
   assign w_cnt_load = (w_state_nxt != r_state);

   always_comb begin
      w_cnt_value = 6'd0;
      case (w_state_nxt)
         SEQ_LOAD, SEQ_UNLOAD: w_cnt_value = 6'(CHAIN_LEN - 1);
         SEQ_COST: w_cnt_value = (data_type == C16L8) ? 6'd15 : 6'd7;
         SEQ_ROOT: w_cnt_value = (data_type == C16L8) ? 6'd7 : 6'd15;
         SEQ_SAVE: w_cnt_value = 6'(SAVE_LEN - 1);
         default: ;
      endcase
   end

   ift_phase_cnt u_phase_cnt (
      .i_clk   (clock),
      .i_rst_n (reset_n),
      .i_load  (w_cnt_load),
      .i_value (w_cnt_value),
      .o_tc    (w_tc)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_nb <= 3'd0;
      end else if (r_state == SEQ_INIT) begin
         r_nb <= 3'd0;
      end else if (r_state == SEQ_SAVE && w_tc) begin
         r_nb <= r_nb + 3'd1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         run          <= 1'b0;
         state        <= STOP_ST;
         carry_in     <= 1'b0;
         mem_receive  <= 1'b0;
         mem_send     <= 1'b0;
         sweep_clr    <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         direction    <= 1'b0;
         sweeps       <= 8'd0;
         timeout      <= 1'b0;
         pathfunction <= 2'b00;
         neighborhood <= 1'b0;
         data_type    <= 1'b0;
      end else begin
         run         <= w_run;
         state       <= w_phase;
         carry_in    <= w_carry;
         mem_receive <= w_recv;
         mem_send    <= w_send;
         sweep_clr   <= w_clr;
         busy        <= w_busy;
         done        <= w_done;
         if (w_accept) begin
            pathfunction <= cfg_pathfunction;
            neighborhood <= cfg_neighborhood;
            data_type    <= cfg_data_type;
            direction    <= 1'b0;
            sweeps       <= 8'd0;
            timeout      <= 1'b0;
         end else if (w_check) begin
            if (sweeps != 8'hFF) sweeps <= sweeps + 8'd1;
            if (any_changed && !w_tmo_hit) direction <= ~direction;
            if (w_tmo_hit) timeout <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ift_seq.sv
// tb/tb_ift_seq.sv - scoreboard bench for ift_seq: directed transforms, re-start, reset, sweep limit.
module tb_ift_seq;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       start = 1'b0;
   logic [1:0] cfg_pathfunction = 2'b00;
   logic       cfg_neighborhood = 1'b0;
   logic       cfg_data_type = 1'b0;
   logic       any_changed = 1'b0;
   logic       run, carry_in, direction, mem_send, mem_receive;
   logic [1:0] state, pathfunction;
   logic       neighborhood, data_type, sweep_clr, busy, done, timeout;
   logic [7:0] sweeps;

   ift_seq #(.MAX_SWEEPS(4)) dut (
      .clock            (clock),
      .reset_n          (reset_n),
      .start            (start),
      .cfg_pathfunction (cfg_pathfunction),
      .cfg_neighborhood (cfg_neighborhood),
      .cfg_data_type    (cfg_data_type),
      .any_changed      (any_changed),
      .run              (run),
      .carry_in         (carry_in),
      .direction        (direction),
      .mem_send         (mem_send),
      .mem_receive      (mem_receive),
      .state            (state),
      .pathfunction     (pathfunction),
      .neighborhood     (neighborhood),
      .data_type        (data_type),
      .sweep_clr        (sweep_clr),
      .busy             (busy),
      .done             (done),
      .timeout          (timeout),
      .sweeps           (sweeps)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {int cyc; int sweeps; int tmo; int nrecv; int nsend; int nclr;} done_exp_t;
   typedef struct {int len; int dir; int nb;} sweep_exp_t;
   done_exp_t  q_done[$];
   sweep_exp_t q_sweep[$];
   int start_cyc = 0;
   int exp_cw = 8;
   int exp_rw = 16;

   // Monitor: checks bus protocol every cycle and pops expectations at sweep ends and done.
   int         m_recv, m_send, m_clr, sw_start, sw_dir, sw_nb, ph_len;
   bit         in_sweep;
   logic [1:0] p_state;
   logic       p_run, p_send, p_busy;
   sweep_exp_t m_se;
   done_exp_t  m_de;

   always @(negedge clock) begin
      if (!reset_n) begin
         m_recv = 0; m_send = 0; m_clr = 0; sw_nb = 0; ph_len = 0;
         in_sweep = 0; p_state = 2'b00; p_run = 0; p_send = 0; p_busy = 0;
      end else begin
         chk("carry_in", int'(carry_in),
             int'(run && (state == 2'b01 || state == 2'b10) && (!p_run || p_state != state)));
         if (p_run && p_state != 2'b00 && (!run || state != p_state) && busy)
            chk($sformatf("phase_len_st%0d", p_state), ph_len,
                (p_state == 2'b01) ? exp_cw : (p_state == 2'b10) ? exp_rw : 28);
         if (run && p_run && state == p_state) ph_len++;
         else ph_len = 1;

         if (in_sweep && (sweep_clr || (mem_send && !p_send))) begin
            chk("sweep_expected", int'(q_sweep.size() > 0), 1);
            if (q_sweep.size() > 0) begin
               m_se = q_sweep.pop_front();
               chk("sweep_len", cyc - sw_start, m_se.len);
               chk("sweep_dir", sw_dir, m_se.dir);
               chk("sweep_nb", sw_nb, m_se.nb);
            end
            in_sweep = 0;
         end
         if (sweep_clr) begin
            in_sweep = 1; sw_start = cyc; sw_dir = int'(direction); sw_nb = 0; m_clr++;
         end
         if (run && state == 2'b11 && !(p_run && p_state == 2'b11)) sw_nb++;
         if (mem_receive) m_recv++;
         if (mem_send) m_send++;

         if (done) begin
            chk("done_expected", int'(q_done.size() > 0), 1);
            if (q_done.size() > 0) begin
               m_de = q_done.pop_front();
               chk("done_cycle", cyc - start_cyc, m_de.cyc);
               chk("done_sweeps", int'(sweeps), m_de.sweeps);
               chk("done_timeout", int'(timeout), m_de.tmo);
               chk("mem_receive_cycles", m_recv, m_de.nrecv);
               chk("mem_send_cycles", m_send, m_de.nsend);
               chk("sweep_clr_pulses", m_clr, m_de.nclr);
            end
            chk("busy_at_done", int'(busy), 0);
            chk("busy_before_done", int'(p_busy), 1);
            m_recv = 0; m_send = 0; m_clr = 0; in_sweep = 0;
         end else if (!busy) begin
            m_recv = 0; m_send = 0; m_clr = 0; in_sweep = 0;
         end
         p_state = state; p_run = run; p_send = mem_send; p_busy = busy;
      end
   end

   task automatic start_run(input logic [1:0] pf, input logic nb, input logic dt,
                            input int cw, input int rw);
      @(negedge clock);
      exp_cw = cw; exp_rw = rw;
      cfg_pathfunction = pf; cfg_neighborhood = nb; cfg_data_type = dt;
      start_cyc = cyc;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   // Drives any_changed per sweep and optionally re-pulses start with altered config.
   task automatic drive(input int n_changed, input int repulse_at, input int bound);
      int         k;
      int         nclr;
      logic [1:0] pf_save;
      logic       nb_save, dt_save;
      nclr = 0;
      pf_save = cfg_pathfunction; nb_save = cfg_neighborhood; dt_save = cfg_data_type;
      any_changed = (n_changed > 0);
      forever begin
         k = cyc - start_cyc;
         if (sweep_clr) begin
            nclr++;
            any_changed = (nclr <= n_changed);
         end
         if (k == repulse_at) begin
            start = 1'b1; cfg_pathfunction = ~pf_save;
            cfg_neighborhood = ~nb_save; cfg_data_type = ~dt_save;
         end else if (k == repulse_at + 1) begin
            start = 1'b0; cfg_pathfunction = pf_save;
            cfg_neighborhood = nb_save; cfg_data_type = dt_save;
         end
         if (done || k >= bound) break;
         @(negedge clock);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clock);
      chk("rst_run", int'(run), 0);
      chk("rst_state", int'(state), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_mem", int'({mem_receive, mem_send, carry_in, sweep_clr}), 0);
      chk("rst_sweeps", int'(sweeps), 0);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);

      // NB=4, C8L16, converges after one sweep
      q_sweep.push_back('{210, 0, 4});
      q_done.push_back('{287, 1, 0, 38, 38, 1});
      start_run(2'b10, 1'b0, 1'b0, 8, 16);
      drive(0, -1, 400);
      chk("A_done_seen", int'(done), 1);
      chk("A_pathfunction", int'(pathfunction), 2);
      chk("A_neighborhood", int'(neighborhood), 0);
      chk("A_direction", int'(direction), 0);
      @(negedge clock);
      chk("A_done_one_cycle", int'(done), 0);
      chk("A_sweeps_hold", int'(sweeps), 1);

      // NB=8, C16L8, two changing sweeps then convergence; start re-pulsed mid-sweep
      q_sweep.push_back('{418, 0, 8});
      q_sweep.push_back('{418, 1, 8});
      q_sweep.push_back('{418, 0, 8});
      q_done.push_back('{1331, 3, 0, 38, 38, 3});
      start_run(2'b01, 1'b1, 1'b1, 16, 8);
      drive(2, 500, 1500);
      chk("B_done_seen", int'(done), 1);
      chk("B_pathfunction", int'(pathfunction), 1);
      chk("B_neighborhood", int'(neighborhood), 1);
      chk("B_data_type", int'(data_type), 1);
      chk("B_direction", int'(direction), 0);
      repeat (2) @(negedge clock);

      // any_changed stuck high
`ifdef IFT_SEQ_TIMEOUT_EN
      for (int i = 0; i < 4; i++) q_sweep.push_back('{210, i % 2, 4});
      q_done.push_back('{917, 4, 1, 38, 38, 4});
      start_run(2'b11, 1'b0, 1'b0, 8, 16);
      drive(1000, -1, 1200);
      chk("C_done_seen", int'(done), 1);
      chk("C_timeout", int'(timeout), 1);
      repeat (2) @(negedge clock);
      chk("C_timeout_hold", int'(timeout), 1);
`else
      for (int i = 0; i < 10; i++) q_sweep.push_back('{210, i % 2, 4});
      start_run(2'b11, 1'b0, 1'b0, 8, 16);
      drive(1000, -1, 2139);
      chk("C_still_busy", int'(busy), 1);
      chk("C_sweeps_10", int'(sweeps), 10);
      chk("C_no_timeout", int'(timeout), 0);
      #2 reset_n = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);
`endif

      // reset asserted in the middle of a ROOT phase
      start_run(2'b10, 1'b0, 1'b0, 8, 16);
      chk("D_timeout_cleared", int'(timeout), 0);
      chk("D_busy", int'(busy), 1);
      for (int i = 0; i < 100 && state != 2'b10; i++) @(negedge clock);
      chk("D_in_root", int'(state), 2);
      repeat (3) @(negedge clock);
      #2 reset_n = 1'b0;
      #1;
      chk("D_rst_run", int'(run), 0);
      chk("D_rst_state", int'(state), 0);
      chk("D_rst_busy", int'(busy), 0);
      chk("D_rst_cfg", int'({pathfunction, direction, sweeps}), 0);
      @(negedge clock);
      chk("D_rst_done", int'(done), 0);
      chk("D_rst_send", int'(mem_send), 0);
      reset_n = 1'b1;
      repeat (5) @(negedge clock);
      chk("D_stays_idle", int'(busy), 0);
      chk("D_no_done", int'(done), 0);

      chk("sweep_queue_empty", q_sweep.size(), 0);
      chk("done_queue_empty", q_done.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
